uart_bootloader_host: RTL
=========================

Name: uart_bootloader_host

Overview:
- Initiator side of the UART bootloader protocol. Turns command descriptors plus a payload byte stream into the UART byte sequence the FPGA-side bootloader expects, then collects the SPI response bytes it returns.
- Sits between a host controller (test harness or soft core) and a `uart` instance.
- Generates the line break the bootloader uses as its protocol reset.

Parameters:
- CLK_FREQ, 12000000, clock frequency in Hz.
- UART_BAUDRATE, 115200, line rate; used only to size the break and the timeout.
- BREAK_BITS, 20, break length in bit times: `BREAK_CYCLES = BREAK_BITS*CLK_FREQ/UART_BAUDRATE`.
- RESP_TIMEOUT_BYTES, 64, idle byte times tolerated in the response phase: `TIMEOUT_CYCLES = RESP_TIMEOUT_BYTES*10*CLK_FREQ/UART_BAUDRATE`.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- cmd_valid  in  1  command descriptor valid
- cmd_ready  out  1  high only in IDLE
- cmd_op  in  1  0 = boot, 1 = transfer
- cmd_tx_len  in  16  payload bytes to write to SPI (transfer only)
- cmd_rx_len  in  16  response bytes to read back (transfer only)
- abort  in  1  single-cycle request: send break, return to IDLE
- wr_valid / wr_ready / wr_data  in / out / 8  payload byte stream
- rd_valid / rd_ready / rd_data  out / in / 8  response byte stream
- uart_tx_valid / uart_tx_ready / uart_tx_data  out / in / 8  to UART transmitter
- uart_rx_valid / uart_rx_ready / uart_rx_data  in / out / 8  from UART receiver
- tx_break  out  1  forces the UART TX line low while high
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse: command completed
- err  out  1  one-cycle pulse: rejected command or response timeout

Behaviour:
- Reset:
  - state = IDLE; all counters = 0.
  - cmd_ready = 1; all other outputs = 0, except uart_rx_ready = 1.
- States: IDLE, BREAK, OPCODE, TXL, TXH, RXL, RXH, PAYLOAD, RESP.
- IDLE, on cmd_valid && cmd_ready:
  - Latch op and both lengths.
  - If op = 1 and (tx_len == 0 or rx_len == 0): pulse err, stay in IDLE. The responder treats 0 as 65536.
  - Otherwise go to BREAK. Every command starts with a break so the responder resynchronises.
- BREAK:
  - tx_break = 1 for BREAK_CYCLES, then 2*BREAK_CYCLES of idle line (guard interval).
  - Then OPCODE, or IDLE if entered via abort or timeout.
- OPCODE:
  - uart_tx_data = {7'b0, op}. The byte is consumed on uart_tx_valid && uart_tx_ready.
  - op = 0: pulse done, go to IDLE. The responder remains in boot until the next break.
  - op = 1: go to TXL.
- Length bytes:
  - TXL/TXH/RXL/RXH send tx_len[7:0], tx_len[15:8], rx_len[7:0], rx_len[15:8], one byte per handshake.
  - RXH goes to PAYLOAD with cnt = 0.
- PAYLOAD:
  - Straight pass-through: uart_tx_valid = wr_valid, wr_ready = uart_tx_ready, uart_tx_data = wr_data.
  - cnt increments on each handshake.
  - On the handshake where cnt == tx_len-1: cnt = 0, go to RESP.
  - wr_ready = 0 in every other state.
- RESP:
  - Pass-through: rd_valid = uart_rx_valid, uart_rx_ready = rd_ready, rd_data = uart_rx_data.
  - cnt increments on each handshake.
  - On the handshake where cnt == rx_len-1: pulse done, go to IDLE.
  - The timeout counter resets on every uart_rx_valid. If it reaches TIMEOUT_CYCLES: pulse err, go to BREAK (resync), then IDLE.
- Outside RESP:
  - uart_rx_ready = 1 and rd_valid = 0, so stray bytes are discarded.
  - uart_tx_valid = 0 outside OPCODE..PAYLOAD.
- abort:
  - In any non-IDLE state, abort goes to BREAK and cancels the current byte. uart_tx_valid drops the next cycle; a byte already accepted by the UART completes on the wire before the break.
  - abort in IDLE is ignored.
  - If abort coincides with a handshake, abort wins for state, but the handshake still counts on the stream side.
- done and err are never asserted in the same cycle.
- Counters are 16 bits; the compare is against len-1 with len != 0, so no wrap-around is possible.

Decomposition:
- Shared package `bootloader_proto`:
  - Opcode constants CMD_BOOT = 8'h00, CMD_TRANSFER = 8'h01.
  - State encoding.
  - The 16-bit length width.
- One natural sub-module, `break_gen`: a cycle counter producing tx_break plus the guard interval, with start/busy handshake.

Test Plan:
- Boot: cmd_op = 0 → tx_break high for BREAK_CYCLES, then UART bytes [00]; done pulses once; cmd_ready returns high.
- Transfer, tx = 3 (AB CD EF), rx = 2:
  - UART bytes [01 03 00 02 00 AB CD EF].
  - Inject rx 55 AA → rd stream 55 AA; done pulses.
- Backpressure: toggle uart_tx_ready and rd_ready at random, tx_len = 0x0102, rx_len = 0x0100 → byte order intact, no drop or duplicate, length bytes [02 01 00 01].
- Reject: cmd_op = 1, tx_len = 0 → err pulse in the accept cycle; no UART activity; busy stays 0.
- Timeout: rx_len = 4, inject 2 bytes then silence → err after TIMEOUT_CYCLES; tx_break asserted; then IDLE with no done.
- Abort mid-PAYLOAD after 5 of 10 bytes → uart_tx_valid = 0 next cycle; tx_break asserted; IDLE; next command starts cleanly with a break.

Source files
------------

// File: rtl/uart_bootloader_host_pkg.sv
// Shared bootloader protocol definitions:
// opcodes, sequencer states and the length width.
package bootloader_proto;

    localparam int LEN_W = 16;

    localparam logic [7:0] CMD_BOOT     = 8'h00;
    localparam logic [7:0] CMD_TRANSFER = 8'h01;

    typedef logic [LEN_W-1:0] len_t;

    typedef enum logic [3:0] {
        S_IDLE,
        S_BREAK,
        S_OPCODE,
        S_TXL,
        S_TXH,
        S_RXL,
        S_RXH,
        S_PAYLOAD,
        S_RESP
    } state_t;

    function automatic logic [7:0] op_byte(input logic op);
        return op ? CMD_TRANSFER : CMD_BOOT;
    endfunction

endpackage

// File: rtl/uart_bootloader_host_if.sv
// Host controller, payload/response streams and UART
// byte channels of the bootloader host, bundled.
interface uart_bootloader_host_if;
    import bootloader_proto::*;

    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_op;
    len_t       cmd_tx_len;
    len_t       cmd_rx_len;
    logic       abort;

    logic       wr_valid;
    logic       wr_ready;
    logic [7:0] wr_data;

    logic       rd_valid;
    logic       rd_ready;
    logic [7:0] rd_data;

    logic       uart_tx_valid;
    logic       uart_tx_ready;
    logic [7:0] uart_tx_data;

    logic       uart_rx_valid;
    logic       uart_rx_ready;
    logic [7:0] uart_rx_data;

    logic       tx_break;
    logic       busy;
    logic       done;
    logic       err;

    modport master (
        output cmd_valid, cmd_op, cmd_tx_len, cmd_rx_len, abort,
        output wr_valid, wr_data, rd_ready,
        output uart_tx_ready, uart_rx_valid, uart_rx_data,
        input  cmd_ready, wr_ready, rd_valid, rd_data,
        input  uart_tx_valid, uart_tx_data, uart_rx_ready,
        input  tx_break, busy, done, err
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_tx_len, cmd_rx_len, abort,
        input  wr_valid, wr_data, rd_ready,
        input  uart_tx_ready, uart_rx_valid, uart_rx_data,
        output cmd_ready, wr_ready, rd_valid, rd_data,
        output uart_tx_valid, uart_tx_data, uart_rx_ready,
        output tx_break, busy, done, err
    );

endinterface

// File: rtl/uart_bootloader_host_break_gen.sv
// Line break generator: BREAK_CYCLES of low line followed
// by a 2*BREAK_CYCLES idle guard, busy for the whole span.
module break_gen #(
    parameter int unsigned BREAK_CYCLES = 2083
) (
    input  logic clk,
    input  logic rst,
    input  logic i_start,
    output logic o_busy,
    output logic o_break
);
    localparam logic [31:0] LAST_BRK = 32'(BREAK_CYCLES - 1);
    localparam logic [31:0] LAST_ALL = 32'(3 * BREAK_CYCLES - 1);

    logic [31:0] r_cnt;
    logic        r_busy;
    logic        r_brk;

    // Count out break then guard; a new start restarts the sequence.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt  <= '0;
            r_busy <= 1'b0;
            r_brk  <= 1'b0;
        end else if (i_start) begin
            r_cnt  <= '0;
            r_busy <= 1'b1;
            r_brk  <= 1'b1;
        end else if (r_busy) begin
            if (r_cnt == LAST_ALL) begin
                r_cnt  <= '0;
                r_busy <= 1'b0;
                r_brk  <= 1'b0;
            end else begin
                r_cnt <= r_cnt + 32'd1;
                if (r_cnt == LAST_BRK) r_brk <= 1'b0;
            end
        end
    end

    assign o_busy  = r_busy;
    assign o_break = r_brk;

endmodule

// File: rtl/uart_bootloader_host.sv
// Host-side UART bootloader initiator: break, opcode, lengths,
// payload pass-through and response collection with timeout.
module uart_bootloader_host
    import bootloader_proto::*;
#(
    parameter int CLK_FREQ           = 12000000,
    parameter int UART_BAUDRATE      = 115200,
    parameter int BREAK_BITS         = 20,
    parameter int RESP_TIMEOUT_BYTES = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    uart_bootloader_host_if.slave bus
);
    localparam longint BRK_L =
        64'(BREAK_BITS) * 64'(CLK_FREQ) / 64'(UART_BAUDRATE);
    localparam longint TMO_L =
        64'(RESP_TIMEOUT_BYTES) * 64'(10) * 64'(CLK_FREQ) / 64'(UART_BAUDRATE);
    localparam logic [31:0] BREAK_CYCLES   = BRK_L[31:0];
    localparam logic [31:0] TIMEOUT_CYCLES = TMO_L[31:0];

    state_t      r_state;
    logic        r_op;
    len_t        r_tx_len;
    len_t        r_rx_len;
    len_t        r_cnt;
    logic [31:0] r_tmo;
    logic        r_ret_idle;

    logic        w_tx_valid;
    logic [7:0]  w_tx_data;
    logic        w_wr_ready;
    logic        w_rd_valid;
    logic [7:0]  w_rd_data;
    logic        w_rx_ready;

    logic        w_accept;
    logic        w_reject;
    logic        w_abort;
    logic        w_tx_hs;
    logic        w_rd_hs;
    logic        w_tx_last;
    logic        w_rx_last;
    logic        w_tmo_hit;
    logic        w_bg_start;
    logic        w_bg_busy;
    logic        w_break;
    logic        w_done;
    logic        w_err;

    assign w_accept  = (r_state == S_IDLE) && bus.cmd_valid;
    assign w_reject  = w_accept && bus.cmd_op &&
                       ((bus.cmd_tx_len == '0) || (bus.cmd_rx_len == '0));
    assign w_abort   = bus.abort && (r_state != S_IDLE);
    assign w_tx_hs   = w_tx_valid && bus.uart_tx_ready;
    assign w_rd_hs   = (r_state == S_RESP) && bus.uart_rx_valid && bus.rd_ready;
    assign w_tx_last = (r_cnt == r_tx_len - 16'd1);
    assign w_rx_last = (r_cnt == r_rx_len - 16'd1);
    assign w_tmo_hit = (r_state == S_RESP) && !bus.uart_rx_valid &&
                       (r_tmo == TIMEOUT_CYCLES);
    assign w_bg_start = (w_accept && !w_reject) || w_abort || w_tmo_hit;

    // An abort cancels the command, so it also suppresses its done/err.
    assign w_done = !w_abort &&
                    (((r_state == S_OPCODE) && w_tx_hs && !r_op) ||
                     (w_rd_hs && w_rx_last));
    assign w_err  = w_reject || (w_tmo_hit && !w_abort);

    break_gen #(
        .BREAK_CYCLES(BREAK_CYCLES)
    ) u_break (
        .clk     (clk),
        .rst     (rst),
        .i_start (w_bg_start),
        .o_busy  (w_bg_busy),
        .o_break (w_break)
    );

    // Byte-channel muxing: header bytes from registers, streams pass through.
    always_comb begin
        w_tx_valid = 1'b0;
        w_tx_data  = 8'h00;
        w_wr_ready = 1'b0;
        w_rd_valid = 1'b0;
        w_rd_data  = 8'h00;
        w_rx_ready = 1'b1;
        unique case (r_state)
            S_OPCODE: begin
                w_tx_valid = 1'b1;
                w_tx_data  = op_byte(r_op);
            end
            S_TXL: begin
                w_tx_valid = 1'b1;
                w_tx_data  = r_tx_len[7:0];
            end
            S_TXH: begin
                w_tx_valid = 1'b1;
                w_tx_data  = r_tx_len[15:8];
            end
            S_RXL: begin
                w_tx_valid = 1'b1;
                w_tx_data  = r_rx_len[7:0];
            end
            S_RXH: begin
                w_tx_valid = 1'b1;
                w_tx_data  = r_rx_len[15:8];
            end
            S_PAYLOAD: begin
                w_tx_valid = bus.wr_valid;
                w_tx_data  = bus.wr_data;
                w_wr_ready = bus.uart_tx_ready;
            end
            S_RESP: begin
                w_rd_valid = bus.uart_rx_valid;
                w_rd_data  = bus.uart_rx_data;
                w_rx_ready = bus.rd_ready;
            end
            default: ;
        endcase
    end

    // Sequencer: break, opcode, lengths, payload, response; abort overrides.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_op       <= 1'b0;
            r_tx_len   <= '0;
            r_rx_len   <= '0;
            r_cnt      <= '0;
            r_tmo      <= '0;
            r_ret_idle <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_op       <= bus.cmd_op;
                        r_tx_len   <= bus.cmd_tx_len;
                        r_rx_len   <= bus.cmd_rx_len;
                        r_cnt      <= '0;
                        r_ret_idle <= 1'b0;
                        if (!w_reject) r_state <= S_BREAK;
                    end
                end
                S_BREAK: begin
                    if (!w_bg_busy)
                        r_state <= r_ret_idle ? S_IDLE : S_OPCODE;
                end
                S_OPCODE: begin
                    if (w_tx_hs) r_state <= r_op ? S_TXL : S_IDLE;
                end
                S_TXL: if (w_tx_hs) r_state <= S_TXH;
                S_TXH: if (w_tx_hs) r_state <= S_RXL;
                S_RXL: if (w_tx_hs) r_state <= S_RXH;
                S_RXH: begin
                    if (w_tx_hs) begin
                        r_cnt   <= '0;
                        r_state <= S_PAYLOAD;
                    end
                end
                S_PAYLOAD: begin
                    if (w_tx_hs) begin
                        if (w_tx_last) begin
                            r_cnt   <= '0;
                            r_tmo   <= '0;
                            r_state <= S_RESP;
                        end else begin
                            r_cnt <= r_cnt + 16'd1;
                        end
                    end
                end
                S_RESP: begin
                    r_tmo <= bus.uart_rx_valid ? 32'd0 : r_tmo + 32'd1;
                    if (w_rd_hs) begin
                        if (w_rx_last) r_state <= S_IDLE;
                        else           r_cnt   <= r_cnt + 16'd1;
                    end else if (w_tmo_hit) begin
                        r_state    <= S_BREAK;
                        r_ret_idle <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
            if (w_abort) begin
                r_state    <= S_BREAK;
                r_ret_idle <= 1'b1;
            end
        end
    end

    assign bus.cmd_ready     = (r_state == S_IDLE);
    assign bus.busy          = (r_state != S_IDLE);
    assign bus.done          = w_done;
    assign bus.err           = w_err;
    assign bus.tx_break      = w_break;
    assign bus.wr_ready      = w_wr_ready;
    assign bus.rd_valid      = w_rd_valid;
    assign bus.rd_data       = w_rd_data;
    assign bus.uart_tx_valid = w_tx_valid;
    assign bus.uart_tx_data  = w_tx_data;
    assign bus.uart_rx_ready = w_rx_ready;

endmodule
